nes_clk_dma_sched: RTL and testbench
====================================

Name: nes_clk_dma_sched

Overview:
Single-clock scheduler for the NES core. It produces PPU and CPU clock-enable strobes from the master clock, so the core uses one clock domain with no derived clocks. It also sequences OAM DMA: on a $4014 write it halts the CPU, performs 256 read/write pairs into $2004, and applies the NES parity alignment (513 or 514 CPU cycles). It sits between the top level, the CPU core's RDY input and the CPU bus mux.

Parameters:
PPU_DIV, 2, master clocks per PPU tick
CPU_DIV, 3, PPU ticks per CPU tick
DMA_LEN, 256, bytes per OAM DMA transfer

Ports:
Clk  in  1  master clock, all logic on posedge
Reset  in  1  asynchronous, active-low reset (asserted when 0)
DMA_Start  in  1  one-Clk pulse; CPU wrote $4014
DMA_Page  in  8  source page, sampled with DMA_Start
DMA_RData  in  8  CPU-bus read data
PPU_CE  out  1  PPU clock enable, one Clk wide
CPU_CE  out  1  CPU clock enable, one Clk wide
CPU_Rdy  out  1  0 halts the CPU core
CPU_Odd  out  1  parity of current CPU cycle
DMA_Busy  out  1  DMA pending or active
DMA_Rd  out  1  DMA owns bus, read cycle
DMA_Wr  out  1  DMA owns bus, write cycle
DMA_Addr  out  16  bus address while DMA_Rd/DMA_Wr
DMA_WData  out  8  write data during DMA_Wr

Behaviour:
- Phase counter ph, 0..PPU_DIV*CPU_DIV-1 (0..5 at defaults), increments every Clk and wraps to 0.
- PPU_CE = (ph mod PPU_DIV == PPU_DIV-1), i.e. phases 1, 3, 5.
- CPU_CE = (ph == PPU_DIV*CPU_DIV-1), i.e. phase 5. It always coincides with a PPU_CE.
- Both strobes are decoded from registered state only, with no combinational input path.
- CPU_Odd toggles on every Clk with CPU_CE.
- Reset values: ph=0, CPU_Odd=0, state=IDLE, pending=0, index=0, page=0, data=0. Outputs: PPU_CE=0, CPU_CE=0, CPU_Rdy=1, DMA_Busy=0, DMA_Rd=0, DMA_Wr=0, DMA_Addr=0, DMA_WData=0.
- With Reset released, the first PPU_CE occurs 1 Clk after the first edge and the first CPU_CE after 5.
- DMA_Start accepted only when state==IDLE and pending==0. On acceptance: pending<=1, page<=DMA_Page. DMA_Start while busy is ignored and the page is not overwritten.
- State machine (enum IDLE, HALT, ALIGN, READ, WRITE). Transitions only on Clk edges with CPU_CE=1:
  IDLE: if pending, go to HALT and clear pending. A start accepted on the same edge as a CPU_CE waits for the next CPU_CE.
  HALT: go to READ if the next cycle is even (CPU_Odd==1 now), otherwise ALIGN.
  ALIGN: go to READ.
  READ: capture data<=DMA_RData, go to WRITE.
  WRITE: if index==DMA_LEN-1, set index<=0 and go to IDLE; otherwise index+1 and go to READ.
- CPU_Rdy = 0 whenever pending or state!=IDLE.
- DMA_Busy = !CPU_Rdy.
- DMA_Rd = (state==READ), DMA_Addr={page,index}.
- DMA_Wr = (state==WRITE), DMA_Addr=16'h2004, DMA_WData=data.
- DMA_Addr=0 otherwise.
- Duration from the HALT entry edge to the IDLE return edge: 513 CPU cycles (HALT entered on an odd cycle) or 514 (even).
- The index is 8 bits and wraps naturally. The DMA_LEN compare governs termination.
- Asserting Reset mid-DMA aborts immediately to reset values. No partial write is held, and CPU_Rdy returns to 1 asynchronously.

Decomposition:
- Package nes_clk_pkg holds:
  - dma_state_t enum (IDLE, HALT, ALIGN, READ, WRITE)
  - OAMDATA_ADDR = 16'h2004
  - DMA_LEN_DEFAULT = 256
  - PHASES = PPU_DIV*CPU_DIV
- Sub-module ce_gen contains the phase counter and PPU_CE/CPU_CE/CPU_Odd generation. It is reusable by the APU frame sequencer.
- The DMA FSM lives in the top of nes_clk_dma_sched.

Test Plan:
- Reset release, run 60 Clk → 30 PPU_CE pulses and 10 CPU_CE pulses, CPU_CE on phase 5 only, never without PPU_CE.
- Pulse DMA_Start with page 8'h02, timed so HALT is entered on an odd cycle → reads 16'h0200..16'h02FF alternate with writes to 16'h2004, DMA_WData echoes the model RAM, CPU_Rdy low 513 CPU cycles from the HALT edge.
- Same start shifted by one CPU cycle (HALT on an even cycle) → one ALIGN cycle and 514 CPU cycles total; the first DMA_Rd begins on an even cycle (CPU_Odd=0).
- Second DMA_Start with page 8'h07 at write #100 → ignored, all addresses keep page 8'h02, exactly 256 writes.
- Assert Reset at read #37 → all outputs return to reset values within the same cycle; a subsequent DMA_Start (page 8'h03) runs a full, clean 256-byte transfer.
- DMA_Start on the same edge as CPU_CE → HALT entered at the following CPU_CE (6 Clk later), not the same edge.

Source files
------------

// File: rtl/nes_clk_pkg.sv
// Shared types and constants for the NES clock-enable / OAM DMA scheduler.
//   dma_state_t      : OAM DMA sequencer states
//   OAMDATA_ADDR     : PPU OAMDATA register ($2004), target of every DMA write
//   DMA_LEN_DEFAULT  : bytes per OAM DMA transfer
//   PPU_DIV_DEFAULT  : master clocks per PPU tick
//   CPU_DIV_DEFAULT  : PPU ticks per CPU tick
//   PHASES           : master clocks per CPU tick at the default ratios
package nes_clk_pkg;

  typedef enum logic [2:0] {
    IDLE,
    HALT,
    ALIGN,
    READ,
    WRITE
  } dma_state_t;

  localparam logic [15:0] OAMDATA_ADDR    = 16'h2004;
  localparam int unsigned DMA_LEN_DEFAULT = 256;
  localparam int unsigned PPU_DIV_DEFAULT = 2;
  localparam int unsigned CPU_DIV_DEFAULT = 3;
  localparam int unsigned PHASES          = PPU_DIV_DEFAULT * CPU_DIV_DEFAULT;

  // Width of a counter holding 0..n-1, never less than one bit.
  function automatic int unsigned phase_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/nes_clk_dma_sched_ce_gen.sv
// Clock-enable generator: a free-running phase counter over one CPU tick
// and the PPU/CPU strobes decoded from it, plus the CPU cycle parity.
//   clk     in  master clock
//   rst_n   in  asynchronous active-low reset
//   ppu_ce  out one-clock PPU enable on the last master clock of each PPU tick
//   cpu_ce  out one-clock CPU enable on the last phase; always with ppu_ce
//   cpu_odd out parity of the current CPU cycle, toggles on each cpu_ce edge
module ce_gen
  import nes_clk_pkg::*;
#(
  parameter int unsigned PPU_DIV = PPU_DIV_DEFAULT,
  parameter int unsigned CPU_DIV = CPU_DIV_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  output logic ppu_ce,
  output logic cpu_ce,
  output logic cpu_odd
);

  localparam int unsigned N  = PPU_DIV * CPU_DIV;
  localparam int unsigned PW = phase_width(N);
  localparam logic [PW-1:0] PH_LAST = PW'(N - 1);

  logic [PW-1:0] ph;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ph      <= '0;
      cpu_odd <= 1'b0;
    end else begin
      ph <= (ph == PH_LAST) ? '0 : ph + 1'b1;
      if (cpu_ce) begin
        cpu_odd <= ~cpu_odd;
      end
    end
  end

  // Decoded from the registered phase only, so no input reaches the strobes.
  always_comb begin
    ppu_ce = ((32'(ph) % PPU_DIV) == (PPU_DIV - 1));
    cpu_ce = (ph == PH_LAST);
  end

endmodule

// File: rtl/nes_clk_dma_sched.sv
// NES single-clock scheduler: PPU/CPU clock enables and the OAM DMA
// sequencer that halts the CPU and copies one page into $2004.
//   Clk        in  master clock
//   Reset      in  asynchronous active-low reset
//   DMA_Start  in  one-clock pulse, CPU wrote $4014
//   DMA_Page   in  source page, sampled with DMA_Start
//   DMA_RData  in  CPU-bus read data
//   PPU_CE     out PPU clock enable
//   CPU_CE     out CPU clock enable
//   CPU_Rdy    out 0 halts the CPU core
//   CPU_Odd    out parity of the current CPU cycle
//   DMA_Busy   out DMA pending or active
//   DMA_Rd     out DMA owns the bus, read cycle
//   DMA_Wr     out DMA owns the bus, write cycle
//   DMA_Addr   out bus address during DMA_Rd/DMA_Wr, else 0
//   DMA_WData  out write data during DMA_Wr, else 0
module nes_clk_dma_sched
  import nes_clk_pkg::*;
#(
  parameter int unsigned PPU_DIV = PPU_DIV_DEFAULT,
  parameter int unsigned CPU_DIV = CPU_DIV_DEFAULT,
  parameter int unsigned DMA_LEN = DMA_LEN_DEFAULT
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        DMA_Start,
  input  logic [7:0]  DMA_Page,
  input  logic [7:0]  DMA_RData,
  output logic        PPU_CE,
  output logic        CPU_CE,
  output logic        CPU_Rdy,
  output logic        CPU_Odd,
  output logic        DMA_Busy,
  output logic        DMA_Rd,
  output logic        DMA_Wr,
  output logic [15:0] DMA_Addr,
  output logic [7:0]  DMA_WData
);

  localparam logic [7:0] LAST_INDEX = 8'(DMA_LEN - 1);

  dma_state_t state;
  logic       pending;
  logic [7:0] index;
  logic [7:0] page;
  logic [7:0] data;

  ce_gen #(
    .PPU_DIV (PPU_DIV),
    .CPU_DIV (CPU_DIV)
  ) u_ce_gen (
    .clk     (Clk),
    .rst_n   (Reset),
    .ppu_ce  (PPU_CE),
    .cpu_ce  (CPU_CE),
    .cpu_odd (CPU_Odd)
  );

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state   <= IDLE;
      pending <= 1'b0;
      index   <= '0;
      page    <= '0;
      data    <= '0;
    end else begin
      // A start may land on any master clock; it is only picked up by the
      // sequencer at the next CPU_CE edge, hence the pending flag.
      if (DMA_Start && (state == IDLE) && !pending) begin
        pending <= 1'b1;
        page    <= DMA_Page;
      end
      if (CPU_CE) begin
        case (state)
          IDLE: begin
            if (pending) begin
              state   <= HALT;
              pending <= 1'b0;
            end
          end
          // Reads must start on an even CPU cycle; if the cycle after
          // HALT would be odd, burn one extra ALIGN cycle.
          HALT:  state <= CPU_Odd ? READ : ALIGN;
          ALIGN: state <= READ;
          READ: begin
            data  <= DMA_RData;
            state <= WRITE;
          end
          WRITE: begin
            if (index == LAST_INDEX) begin
              index <= '0;
              state <= IDLE;
            end else begin
              index <= index + 8'd1;
              state <= READ;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  always_comb begin
    CPU_Rdy   = !pending && (state == IDLE);
    DMA_Busy  = pending || (state != IDLE);
    DMA_Rd    = (state == READ);
    DMA_Wr    = (state == WRITE);
    DMA_Addr  = '0;
    DMA_WData = '0;
    if (state == READ) begin
      DMA_Addr = {page, index};
    end else if (state == WRITE) begin
      DMA_Addr  = OAMDATA_ADDR;
      DMA_WData = data;
    end
  end

endmodule

// File: tb/tb_nes_clk_dma_sched.sv
// Self-checking bench for nes_clk_dma_sched: strobe cadence, a table of
// per-clock vectors around a DMA start, and full DMA transfers covering
// parity alignment, ignored restarts, mid-transfer reset and CE-edge starts.
module tb_nes_clk_dma_sched;

  logic        Clk;
  logic        Reset;
  logic        DMA_Start;
  logic [7:0]  DMA_Page;
  logic [7:0]  DMA_RData;
  logic        PPU_CE;
  logic        CPU_CE;
  logic        CPU_Rdy;
  logic        CPU_Odd;
  logic        DMA_Busy;
  logic        DMA_Rd;
  logic        DMA_Wr;
  logic [15:0] DMA_Addr;
  logic [7:0]  DMA_WData;

  int checks;
  int errors;

  nes_clk_dma_sched #(
    .PPU_DIV (2),
    .CPU_DIV (3),
    .DMA_LEN (256)
  ) dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .DMA_Start (DMA_Start),
    .DMA_Page  (DMA_Page),
    .DMA_RData (DMA_RData),
    .PPU_CE    (PPU_CE),
    .CPU_CE    (CPU_CE),
    .CPU_Rdy   (CPU_Rdy),
    .CPU_Odd   (CPU_Odd),
    .DMA_Busy  (DMA_Busy),
    .DMA_Rd    (DMA_Rd),
    .DMA_Wr    (DMA_Wr),
    .DMA_Addr  (DMA_Addr),
    .DMA_WData (DMA_WData)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  // Model memory: each address holds a byte derived from its page and offset.
  function automatic logic [7:0] ram_byte(input logic [15:0] a);
    return (a[7:0] ^ 8'h5A) + a[15:8];
  endfunction

  always_comb DMA_RData = ram_byte(DMA_Addr);

  typedef struct {
    logic        start;
    logic [7:0]  page;
    logic        ppu;
    logic        cpu;
    logic        odd;
    logic        rdy;
    logic        rd;
    logic [15:0] addr;
  } vec_t;

  vec_t vecs[14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, ".PPU_CE"},    32'(PPU_CE),    32'd0);
    chk({tag, ".CPU_CE"},    32'(CPU_CE),    32'd0);
    chk({tag, ".CPU_Rdy"},   32'(CPU_Rdy),   32'd1);
    chk({tag, ".CPU_Odd"},   32'(CPU_Odd),   32'd0);
    chk({tag, ".DMA_Busy"},  32'(DMA_Busy),  32'd0);
    chk({tag, ".DMA_Rd"},    32'(DMA_Rd),    32'd0);
    chk({tag, ".DMA_Wr"},    32'(DMA_Wr),    32'd0);
    chk({tag, ".DMA_Addr"},  32'(DMA_Addr),  32'd0);
    chk({tag, ".DMA_WData"}, 32'(DMA_WData), 32'd0);
  endtask

  // Leaves the bench at a falling edge with reset just released; the next
  // rising edge is edge 1.
  task automatic apply_reset();
    Reset     = 1'b0;
    DMA_Start = 1'b0;
    DMA_Page  = 8'h00;
    @(negedge Clk);
    @(negedge Clk);
    Reset = 1'b1;
  endtask

  // Starts a DMA after 'pre' idle edges and follows it to completion.
  //   exp_wait     : edges from the accepting edge to the HALT entry edge
  //   exp_first_rd : edges from HALT entry to the first read
  //   exp_cycles   : CPU cycles from HALT entry to the IDLE return edge
  //   inject       : pulse a second start (page 07) at write #100
  //   abort_at     : assert Reset at this read index (-1 = never)
  task automatic run_dma(input logic [7:0] pg, input int pre, input int exp_wait,
                         input int exp_first_rd, input int exp_cycles,
                         input bit inject, input int abort_at);
    int         rd_cnt;
    int         wr_cnt;
    int         wait_e;
    int         cyc;
    int         first_rd;
    bit         armed;
    bit         done;
    bit         aborted;
    logic       ce_now;
    logic [7:0] idx;
    rd_cnt   = 0;
    wr_cnt   = 0;
    wait_e   = 0;
    cyc      = 0;
    first_rd = -1;
    armed    = 1'b0;
    done     = 1'b0;
    aborted  = 1'b0;
    repeat (pre) @(negedge Clk);
    DMA_Start = 1'b1;
    DMA_Page  = pg;
    @(negedge Clk);
    DMA_Start = 1'b0;
    DMA_Page  = 8'h00;
    chk("pending_rdy",  32'(CPU_Rdy),  32'd0);
    chk("pending_busy", 32'(DMA_Busy), 32'd1);
    for (int t = 0; t < 5000 && !done; t++) begin
      if (armed && CPU_Rdy) begin
        done = 1'b1;
      end else if (abort_at >= 0 && DMA_Rd && rd_cnt == abort_at) begin
        idx = 8'(abort_at);
        chk("abort_rd_addr", 32'(DMA_Addr), 32'({pg, idx}));
        Reset = 1'b0;
        #1;
        check_reset_outputs("abort");
        aborted = 1'b1;
        done    = 1'b1;
      end else begin
        if (DMA_Rd && first_rd < 0) begin
          first_rd = cyc;
          chk("first_rd_odd", 32'(CPU_Odd), 32'd0);
        end
        if (CPU_CE) begin
          if (DMA_Rd) begin
            idx = rd_cnt[7:0];
            chk("rd_addr", 32'(DMA_Addr), 32'({pg, idx}));
            chk("rd_no_wr", 32'(DMA_Wr), 32'd0);
            rd_cnt++;
          end else if (DMA_Wr) begin
            idx = wr_cnt[7:0];
            chk("wr_addr", 32'(DMA_Addr), 32'h2004);
            chk("wr_data", 32'(DMA_WData), 32'(ram_byte({pg, idx})));
            if (inject && wr_cnt == 100) begin
              DMA_Start = 1'b1;
              DMA_Page  = 8'h07;
            end
            wr_cnt++;
          end else if (armed) begin
            chk("halt_addr", 32'(DMA_Addr), 32'd0);
          end
          if (armed) begin
            chk("active_rdy",  32'(CPU_Rdy),  32'd0);
            chk("active_busy", 32'(DMA_Busy), 32'd1);
          end
        end
        ce_now = CPU_CE;
        @(posedge Clk);
        if (armed) cyc++;
        else wait_e++;
        if (ce_now && !armed) armed = 1'b1;
        @(negedge Clk);
        DMA_Start = 1'b0;
        DMA_Page  = 8'h00;
      end
    end
    chk("dma_timeout", 32'(done), 32'd1);
    if (done && !aborted) begin
      chk("rd_count",    32'(rd_cnt),   32'd256);
      chk("wr_count",    32'(wr_cnt),   32'd256);
      chk("halt_wait",   32'(wait_e),   32'(exp_wait));
      chk("first_rd",    32'(first_rd), 32'(exp_first_rd));
      chk("dma_edges",   32'(cyc),      32'(6 * exp_cycles));
      chk("end_busy",    32'(DMA_Busy), 32'd0);
      chk("end_addr",    32'(DMA_Addr), 32'd0);
    end
  endtask

  int ppu_n;
  int cpu_n;
  int ph;

  initial begin
    checks    = 0;
    errors    = 0;
    Reset     = 1'b1;
    DMA_Start = 1'b0;
    DMA_Page  = 8'h00;

    //          start page   ppu  cpu  odd  rdy  rd   addr
    vecs[0]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000};
    vecs[1]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000};
    vecs[2]  = '{1'b1, 8'h11, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000};
    vecs[3]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000};
    vecs[4]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000};
    vecs[5]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000};
    vecs[6]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000};
    vecs[7]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000};
    vecs[8]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000};
    vecs[9]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000};
    vecs[10] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0000};
    vecs[11] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h1100};
    vecs[12] = '{1'b1, 8'h22, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16'h1100};
    vecs[13] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h1100};

    // Asynchronous reset asserted between clock edges.
    #2 Reset = 1'b0;
    #1 check_reset_outputs("por");

    // Strobe cadence over 60 master clocks.
    apply_reset();
    ppu_n = 0;
    cpu_n = 0;
    for (int n = 1; n <= 60; n++) begin
      @(posedge Clk);
      @(negedge Clk);
      ph = n % 6;
      chk("cad_ppu", 32'(PPU_CE), 32'(ph % 2 == 1));
      chk("cad_cpu", 32'(CPU_CE), 32'(ph == 5));
      chk("cad_odd", 32'(CPU_Odd), 32'((n / 6) % 2));
      if (CPU_CE) chk("cad_cpu_with_ppu", 32'(PPU_CE), 32'd1);
      if (PPU_CE) ppu_n++;
      if (CPU_CE) cpu_n++;
    end
    chk("cad_ppu_count", 32'(ppu_n), 32'd30);
    chk("cad_cpu_count", 32'(cpu_n), 32'd10);

    // Per-clock vectors: start on edge 3, HALT at edge 6, first read at edge 12.
    // The second start (page 22) arrives while busy and must not change the page.
    apply_reset();
    for (int i = 0; i < 14; i++) begin
      DMA_Start = vecs[i].start;
      DMA_Page  = vecs[i].page;
      @(posedge Clk);
      @(negedge Clk);
      DMA_Start = 1'b0;
      DMA_Page  = 8'h00;
      chk("vec_ppu",  32'(PPU_CE),   32'(vecs[i].ppu));
      chk("vec_cpu",  32'(CPU_CE),   32'(vecs[i].cpu));
      chk("vec_odd",  32'(CPU_Odd),  32'(vecs[i].odd));
      chk("vec_rdy",  32'(CPU_Rdy),  32'(vecs[i].rdy));
      chk("vec_busy", 32'(DMA_Busy), 32'(!vecs[i].rdy));
      chk("vec_rd",   32'(DMA_Rd),   32'(vecs[i].rd));
      chk("vec_addr", 32'(DMA_Addr), 32'(vecs[i].addr));
    end

    // HALT on an odd cycle, second start at write #100 ignored: 513 cycles.
    apply_reset();
    run_dma(8'h02, 2, 3, 6, 513, 1'b1, -1);

    // Start on the CPU_CE edge: HALT six clocks later, on an even cycle,
    // so one ALIGN cycle is inserted: 514 cycles.
    apply_reset();
    run_dma(8'h02, 5, 6, 12, 514, 1'b0, -1);

    // Reset during read #37, then a clean full transfer from page 03.
    apply_reset();
    run_dma(8'h02, 2, 3, 6, 513, 1'b0, 37);
    apply_reset();
    run_dma(8'h03, 2, 3, 6, 513, 1'b0, -1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
